// File: rtl/sbox_share_sched.sv
// Shared SubBytes/SubWord engine: LANES sbox instances time-multiplexed between a
// 128-bit data requester and a 32-bit key requester. Define SBOX_SHARE_KEY_PRIO_EN for fixed key priority.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Inverse as a^254 (square-and-multiply), which maps 0 to 0 as the affine step expects
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sbox_share_sched #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d_valid,
    output logic         d_ready,
    input  logic [127:0] d_data,
    input  logic         k_valid,
    output logic         k_ready,
    input  logic [31:0]  k_data,
    output logic         d_out_valid,
    output logic [127:0] d_out,
    output logic         k_out_valid,
    output logic [31:0]  k_out,
    output logic         busy
);
    localparam int DB = 16 / LANES;
    localparam int KB = (LANES >= 4) ? 1 : 4 / LANES;
    localparam int CW = (DB > 1) ? $clog2(DB) : 1;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("sbox_share_sched: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN_D, RUN_K} state_t;

    state_t                  state;
    logic [127:0]            wbuf;
    logic [127:0]            nxt_buf;
    logic [CW-1:0]           beat;
    logic [LANES-1:0][7:0]   sb_in;
    logic [LANES-1:0][7:0]   sb_out;
    logic                    grant_k;
    logic                    grant_d;
    logic                    last_beat;

`ifdef SBOX_SHARE_KEY_PRIO_EN
    assign grant_k = k_valid;
`else
    logic rr_key;
    assign grant_k = k_valid && (!d_valid || rr_key);
`endif
    assign grant_d = d_valid && !grant_k;

    assign k_ready = !rst && (state == IDLE) && grant_k;
    assign d_ready = !rst && (state == IDLE) && grant_d;
    assign busy    = (state != IDLE);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox u_sbox (.a(sb_in[l]), .y(sb_out[l]));
    end

    // Lane l handles byte beat*LANES+l; key words only ever touch bytes 0..3
    always_comb begin
        nxt_buf = wbuf;
        sb_in   = '0;
        for (int l = 0; l < LANES; l++) begin
            sb_in[l] = wbuf[8*(int'(beat)*LANES + l) +: 8];
            if (state == RUN_D || (state == RUN_K && l < 4))
                nxt_buf[8*(int'(beat)*LANES + l) +: 8] = sb_out[l];
        end
    end

    assign last_beat = (state == RUN_D) ? (beat == CW'(DB - 1)) : (beat == CW'(KB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wbuf        <= '0;
            beat        <= '0;
            d_out       <= '0;
            k_out       <= '0;
            d_out_valid <= 1'b0;
            k_out_valid <= 1'b0;
`ifndef SBOX_SHARE_KEY_PRIO_EN
            rr_key      <= 1'b1;
`endif
        end else begin
            d_out_valid <= 1'b0;
            k_out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (k_ready) begin
                        wbuf  <= {96'b0, k_data};
                        state <= RUN_K;
`ifndef SBOX_SHARE_KEY_PRIO_EN
                        rr_key <= 1'b0;
`endif
                    end else if (d_ready) begin
                        wbuf  <= d_data;
                        state <= RUN_D;
`ifndef SBOX_SHARE_KEY_PRIO_EN
                        rr_key <= 1'b1;
`endif
                    end
                end
                RUN_D, RUN_K: begin
                    wbuf <= nxt_buf;
                    if (last_beat) begin
                        state <= IDLE;
                        beat  <= '0;
                        if (state == RUN_D) begin
                            d_out       <= nxt_buf;
                            d_out_valid <= 1'b1;
                        end else begin
                            k_out       <= nxt_buf[31:0];
                            k_out_valid <= 1'b1;
                        end
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_share_sched.sv
// Bench for sbox_share_sched: directed and random traffic on a LANES=4 instance
// checked against a transaction-level model, plus a latency sweep over other LANES values.

module tb_sbox_share_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic         d_valid, d_ready, k_valid, k_ready;
    logic         d_out_valid, k_out_valid, busy;
    logic [127:0] d_data, d_out;
    logic [31:0]  k_data, k_out;

    always #5 clk = ~clk;

    sbox_share_sched #(.LANES(4)) dut (
        .clk(clk), .rst(rst),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data),
        .d_out_valid(d_out_valid), .d_out(d_out),
        .k_out_valid(k_out_valid), .k_out(k_out),
        .busy(busy)
    );

    localparam int SW_L [4] = '{1, 2, 8, 16};
    logic         sw_dv [4], sw_dr [4], sw_kv [4], sw_kr [4];
    logic         sw_dov [4], sw_kov [4], sw_busy [4];
    logic [127:0] sw_dd [4], sw_do [4];
    logic [31:0]  sw_kd [4], sw_ko [4];

    for (genvar j = 0; j < 4; j++) begin : g_sw
        sbox_share_sched #(.LANES(SW_L[j])) u_sw (
            .clk(clk), .rst(rst),
            .d_valid(sw_dv[j]), .d_ready(sw_dr[j]), .d_data(sw_dd[j]),
            .k_valid(sw_kv[j]), .k_ready(sw_kr[j]), .k_data(sw_kd[j]),
            .d_out_valid(sw_dov[j]), .d_out(sw_do[j]),
            .k_out_valid(sw_kov[j]), .k_out(sw_ko[j]),
            .busy(sw_busy[j])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference S-box: field inverse by exhaustive search, then the AES affine map
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sb(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        logic [7:0] r;
        for (int y = 1; y < 256; y++)
            if (gm(x, 8'(y)) == 8'h01) v = 8'(y);
        r = 8'h63;
        for (int s = 0; s < 5; s++) r ^= (v << s) | (v >> (8 - s));
        return r;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] x, input int nbytes);
        logic [127:0] r = '0;
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = ref_sb(x[8*i +: 8]);
        return r;
    endfunction

    localparam int L = 4;
    int           m_left = 0;
    bit           m_side_k, m_rr = 1'b1, e_dv = 1'b0, e_kv = 1'b0, acc_d, acc_k;
    logic [127:0] m_res, m_dout = '0;
    logic [31:0]  m_kout = '0;
    int           cyc = 0, dpulse = -1, kpulse = -1;

    task automatic model_reset();
        m_left = 0; m_rr = 1'b1; e_dv = 1'b0; e_kv = 1'b0; m_dout = '0; m_kout = '0;
    endtask

    // One clock: check registered outputs, apply inputs, check readies, advance the model
    task automatic cycle(input logic dv, input logic [127:0] dd, input logic kv, input logic [31:0] kd);
        bit gk, gd;
        @(negedge clk);
        chk("d_out_valid", d_out_valid, e_dv);
        chk("k_out_valid", k_out_valid, e_kv);
        chk("d_out", d_out, m_dout);
        chk("k_out", k_out, m_kout);
        chk("busy", busy, m_left > 0);
        if (d_out_valid) dpulse = cyc - 1;
        if (k_out_valid) kpulse = cyc - 1;
        d_valid = dv; d_data = dd; k_valid = kv; k_data = kd;
        #1;
`ifdef SBOX_SHARE_KEY_PRIO_EN
        gk = (m_left == 0) && kv;
`else
        gk = (m_left == 0) && kv && (!dv || m_rr);
`endif
        gd = (m_left == 0) && dv && !gk;
        chk("k_ready", k_ready, gk);
        chk("d_ready", d_ready, gd);
        chk("ready_excl", d_ready && k_ready, 1'b0);
        acc_d = gd; acc_k = gk;
        e_dv = 1'b0; e_kv = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_side_k) begin m_kout = m_res[31:0]; e_kv = 1'b1; end
                else begin m_dout = m_res; e_dv = 1'b1; end
            end
        end else if (gk) begin
            m_left = (4 / L > 1) ? 4 / L : 1; m_side_k = 1'b1;
            m_res = ref_sub({96'b0, kd}, 4); m_rr = 1'b0;
        end else if (gd) begin
            m_left = 16 / L; m_side_k = 1'b0; m_res = ref_sub(dd, 16); m_rr = 1'b1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; d_valid = 1'b1; k_valid = 1'b1;
        #1;
        chk("rst_d_ready", d_ready, 1'b0);
        chk("rst_k_ready", k_ready, 1'b0);
        chk("rst_outs", {d_out_valid, k_out_valid, busy, d_out, k_out}, '0);
        @(negedge clk);
        rst = 1'b0; d_valid = 1'b0; k_valid = 1'b0;
        model_reset();
    endtask

    initial begin
        int acc_cyc, n, b2b_seen;
        bit g [$];
        bit pend_d, pend_k;
        logic [127:0] dd;
        logic [31:0] kd;

        rst = 1'b1; d_valid = 1'b0; k_valid = 1'b0; d_data = '0; k_data = '0;
        for (int j = 0; j < 4; j++) begin
            sw_dv[j] = 1'b0; sw_kv[j] = 1'b0; sw_dd[j] = '0; sw_kd[j] = '0;
        end
        #12;
        do_reset();

        // Data only, all-zero state
        acc_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            cycle(acc_cyc < 0, '0, 1'b0, '0);
            if (acc_d) acc_cyc = cyc - 1;
        end
        chk("d_zero_acc_first", acc_cyc, 0 + cyc - 8);
        chk("d_zero_lat", dpulse - acc_cyc, 4);
        chk("d_zero_out", d_out, {16{8'h63}});

        // Key only
        acc_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, acc_cyc < 0, 32'h0153ff00);
            if (acc_k) acc_cyc = cyc - 1;
        end
        chk("k_lat", kpulse - acc_cyc, 1);
        chk("k_out_vec", k_out, 32'h7ced1663);

        // Both valid continuously from reset
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, {4{32'h00112233 + 32'(i)}}, 1'b1, 32'hdeadbeef);
            if (acc_k) g.push_back(1'b1);
            if (acc_d) g.push_back(1'b0);
        end
        chk("grant_count", g.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < g.size(); i++) begin
`ifdef SBOX_SHARE_KEY_PRIO_EN
            chk("grant_order", g[i], 1'b1);
`else
            chk("grant_order", g[i], (i % 2) == 0);
`endif
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, '0);

        // Back-to-back data: second accept coincides with first d_out_valid
        n = 0; b2b_seen = 0;
        while (n < 20 && b2b_seen == 0) begin
            cycle(1'b1, (n < 1) ? {8{16'h1234}} : {16{8'hff}}, 1'b0, '0);
            if (acc_d && n > 0) begin
                b2b_seen = 1;
                chk("b2b_same_cycle", d_out_valid, 1'b1);
            end
            n++;
        end
        chk("b2b_accepted", b2b_seen, 1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, '0);
        chk("b2b_ff_out", d_out, {16{8'h16}});

        // Reset at beat 2 of a data request
        cycle(1'b1, {4{32'hcafef00d}}, 1'b0, '0);
        chk("mid_acc", acc_d, 1'b1);
        cycle(1'b0, '0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, '0);
        cycle(1'b1, {4{32'h0badc0de}}, 1'b0, '0);
        chk("post_rst_acc", acc_d, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, '0);
        chk("post_rst_out", d_out, ref_sub({4{32'h0badc0de}}, 16));

        // Random traffic; requesters hold valid and data until accepted
        pend_d = 1'b0; pend_k = 1'b0; dd = '0; kd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                pend_d = 1'b1; dd = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!pend_k && $urandom_range(0, 2) == 0) begin
                pend_k = 1'b1; kd = $urandom;
            end
            cycle(pend_d, pend_d ? dd : {$urandom, 96'b0}, pend_k, pend_k ? kd : $urandom);
            if (acc_d) pend_d = 1'b0;
            if (acc_k) pend_k = 1'b0;
        end

        // LANES sweep
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            sw_dv[j] = 1'b1;
            sw_dd[j] = 128'h0f0e0d0c0b0a09080706050403020100;
            #1;
            chk("sw_ready", sw_dr[j], 1'b1);
            @(negedge clk);
            sw_dv[j] = 1'b0;
            n = 0;
            while (!sw_dov[j] && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("sw_lat_L%0d", SW_L[j]), n, 16 / SW_L[j]);
            chk($sformatf("sw_out_L%0d", SW_L[j]), sw_do[j], 128'h76abd7fe2b670130c56f6bf27b777c63);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
